// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding,
// address increment and the default reset fetch address.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_INC        = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_seq_perf.sv
// Fetch performance counters: accepted instructions and decode-stall cycles.
// Only instantiated when FETCH_SEQ_PERF_EN is defined.
module fetch_seq_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetched_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      if (fetched_inc) perf_fetched <= perf_fetched + 32'd1;
      if (stall_inc)   perf_stall   <= perf_stall + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch-stage sequencer: owns the fetch address, drives the instruction-memory
// handshake and presents one instruction per cycle to decode.
// Optional performance counters are enabled with FETCH_SEQ_PERF_EN.
//
//   state | meaning
//   IDLE  | just out of reset, no request yet
//   REQ   | requesting faddr, accepting responses into the decode slot
//   DROP  | redirect hit an in-flight request; waiting to discard its response
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        validF,
  output logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic [31:0] pcplus4F
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  faddr;
  logic [31:0]  stale_addr;
  logic         slot_free;
  logic         accept;
  logic         redir;

  assign slot_free = !validF || !stallF;
  assign redir     = redirect_valid && (state != IDLE);
  assign accept    = (state == REQ) && imem_rvalid && slot_free && !redirect_valid;
  assign pcplus4F  = pcF + FETCH_INC;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (redirect_valid && !imem_rvalid) state_nxt = DROP;
        else                                state_nxt = REQ;
      end
      DROP: begin
        if (!redirect_valid && imem_rvalid) state_nxt = REQ;
        else                                state_nxt = DROP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // While dropping, the bus must keep showing the stale address until its
  // response arrives; faddr already holds the redirect target.
  always_comb begin
    imem_req  = (state != IDLE);
    imem_addr = (state == DROP) ? stale_addr : faddr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      faddr      <= RESET_PC;
      stale_addr <= RESET_PC;
      validF     <= 1'b0;
      instrF     <= 32'd0;
      pcF        <= RESET_PC;
    end else if (redir) begin
      faddr  <= word_align(redirect_pc);
      validF <= 1'b0;
      if (state == REQ) stale_addr <= faddr;
    end else if (accept) begin
      instrF <= imem_rdata;
      pcF    <= faddr;
      validF <= 1'b1;
      faddr  <= faddr + FETCH_INC;
    end else if (validF && !stallF) begin
      validF <= 1'b0;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  fetch_seq_perf u_perf (
    .clk          (clk),
    .reset        (reset),
    .fetched_inc  (accept),
    .stall_inc    (validF && stallF),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a configurable-latency memory model
// that returns addr>>2 as the instruction word.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        validF;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic [31:0] pcplus4F;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Memory model: a request is answered once it has been presented for
  // more than lat consecutive cycles at the same address.
  int          lat = 0;
  int          cnt = 0;
  int          age;
  logic        last_req = 1'b0;
  logic [31:0] last_addr = 32'd0;

  always #5 clk = ~clk;

  assign age         = (imem_req && last_req && imem_addr == last_addr) ? cnt : 0;
  assign imem_rvalid = imem_req && (age >= lat);
  assign imem_rdata  = imem_addr >> 2;

  always @(posedge clk) begin
    last_req  <= imem_req;
    last_addr <= imem_addr;
    cnt       <= imem_req ? age + 1 : 0;
  end

  fetch_seq dut (
    .clk            (clk),
    .reset          (reset),
    .stallF         (stallF),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .validF         (validF),
    .instrF         (instrF),
    .pcF            (pcF),
    .pcplus4F       (pcplus4F)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] pc);
    check({tag, " validF"}, {31'd0, validF}, {31'd0, v});
    check({tag, " instrF"}, instrF, ins);
    check({tag, " pcF"}, pcF, pc);
    check({tag, " pcplus4F"}, pcplus4F, pc + 32'd4);
  endtask

  initial begin
    reset = 1'b1;
    stallF = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    repeat (3) step();

    check("rst req", {31'd0, imem_req}, 32'd0);
    check("rst addr", imem_addr, 32'h0);
    check_out("rst", 1'b0, 32'd0, 32'd0);

    reset = 1'b0;
    step();  // IDLE -> REQ
    check("first req", {31'd0, imem_req}, 32'd1);
    check("first addr", imem_addr, 32'h0);
    check("first valid", {31'd0, validF}, 32'd0);
    step();
    check_out("i0", 1'b1, 32'd0, 32'd0);
    check("i0 addr", imem_addr, 32'd4);
    step();
    check_out("i1", 1'b1, 32'd1, 32'd4);
    step();
    check_out("i2", 1'b1, 32'd2, 32'd8);
    check("i2 addr", imem_addr, 32'd12);

    // Decode back-pressure for three cycles.
    stallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall", 1'b1, 32'd2, 32'd8);
      check("stall req", {31'd0, imem_req}, 32'd1);
      check("stall addr", imem_addr, 32'd12);
    end
    stallF = 1'b0;
    step();
    check_out("i3", 1'b1, 32'd3, 32'd12);
    step();
    check_out("i4", 1'b1, 32'd4, 32'd16);
    check("i4 addr", imem_addr, 32'd20);

    // Redirect coincident with rvalid and a stall: response dropped.
    stallF = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0013;
    step();
    check("redir valid", {31'd0, validF}, 32'd0);
    check("redir addr", imem_addr, 32'h10);
    check("redir req", {31'd0, imem_req}, 32'd1);

    // Slow memory; second redirect lands while 0x10 is in flight.
    redirect_valid = 1'b0;
    stallF = 1'b0;
    lat = 2;
    step();
    check("slow wait addr", imem_addr, 32'h10);
    check("slow wait valid", {31'd0, validF}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    check("drop addr", imem_addr, 32'h10);
    check("drop req", {31'd0, imem_req}, 32'd1);
    check("drop valid", {31'd0, validF}, 32'd0);
    step();
    check("after drop addr", imem_addr, 32'h100);
    check("after drop valid", {31'd0, validF}, 32'd0);
    step();
    check("tgt wait1", {31'd0, validF}, 32'd0);
    step();
    check("tgt wait2", {31'd0, validF}, 32'd0);
    check("tgt wait2 addr", imem_addr, 32'h100);
    step();
    check_out("tgt", 1'b1, 32'h40, 32'h100);
    check("tgt next addr", imem_addr, 32'h104);

    // Address wrap at the top of memory.
    lat = 0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    check("wrap redir addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap redir valid", {31'd0, validF}, 32'd0);
    step();
    check("wrap validF", {31'd0, validF}, 32'd1);
    check("wrap pcF", pcF, 32'hFFFF_FFFC);
    check("wrap instrF", instrF, 32'h3FFF_FFFF);
    check("wrap pcplus4F", pcplus4F, 32'h0);
    check("wrap next addr", imem_addr, 32'h0);
    step();
    check_out("post wrap", 1'b1, 32'd0, 32'd0);

    // Reset mid-stream.
    reset = 1'b1;
    step();
    check("mid rst req", {31'd0, imem_req}, 32'd0);
    check("mid rst addr", imem_addr, 32'h0);
    check_out("mid rst", 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    step();
    check("restart req", {31'd0, imem_req}, 32'd1);
    check("restart addr", imem_addr, 32'h0);

`ifdef FETCH_SEQ_PERF_EN
    reset = 1'b1;
    step();
    check("perf rst fetched", perf_fetched, 32'd0);
    check("perf rst stall", perf_stall, 32'd0);
    reset = 1'b0;
    repeat (5) step();
    stallF = 1'b1;
    repeat (4) step();
    stallF = 1'b0;
    repeat (6) step();
    check("perf fetched", perf_fetched, 32'd10);
    check("perf stall", perf_stall, 32'd4);
    reset = 1'b1;
    step();
    check("perf clr fetched", perf_fetched, 32'd0);
    check("perf clr stall", perf_stall, 32'd0);
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Fetch-stage sequencer for the pipelined MIPS core. Owns the fetch address, drives a variable-latency instruction-memory request/response handshake, and presents one instruction per cycle to decode with its PC+4. Honours decode back-pressure (`stallF`) and branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stallF`  in  1  decode cannot accept a new instruction this cycle.
- `redirect_valid`  in  1  branch/jump taken; flush fetch.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored, forced to 0.
- `imem_req`  out  1  request to instruction memory.
- `imem_addr`  out  32  request address; word-aligned.
- `imem_rvalid`  in  1  response valid. Memory holds `rvalid`/`rdata` stable while `imem_req` stays high.
- `imem_rdata`  in  32  instruction word.
- `validF`  out  1  `instrF` holds a live instruction.
- `instrF`  out  32  fetched instruction.
- `pcF`  out  32  address of `instrF`.
- `pcplus4F`  out  32  `pcF + 4`, combinational, modulo 2^32.

## Operation
- States: IDLE, REQ, DROP.
  - IDLE: only after reset. Goes to REQ next cycle.
  - REQ: `imem_req=1`, `imem_addr=faddr`.
  - DROP: `imem_req=1` at the old address; waits for the stale response to discard.
- slot_free = !validF | !stallF.
- Accept = REQ & imem_rvalid & slot_free & !redirect_valid. On accept:
  - `instrF <= imem_rdata`, `pcF <= faddr`, `validF <= 1`.
  - `faddr <= faddr + 4`, wrapping modulo 2^32.
  - Stay in REQ.
- `imem_rvalid` with !slot_free: response is not accepted; `imem_req`/`imem_addr` held; output regs held.
- `validF` & !stallF & no accept: `validF <= 0`.
- `validF` & stallF: `instrF`, `pcF`, `validF` held.
- `redirect_valid` (highest priority, any state except IDLE):
  - `validF <= 0`; `faddr <= {redirect_pc[31:2],2'b00}`.
  - If REQ & imem_rvalid this cycle: response discarded; next state REQ at new address.
  - If REQ & !imem_rvalid: next state DROP.
  - If DROP: target updated to latest redirect; stay DROP.
- DROP & imem_rvalid & !redirect_valid: response discarded; next state REQ.
- Redirect overrides `stallF`.

## Timing
- Reset values: `imem_req=0`, `imem_addr=RESET_PC`, `validF=0`, `instrF=0`, `pcF=RESET_PC`, `pcplus4F=RESET_PC+4`, state IDLE.
- First request issues on the first cycle after `reset` deasserts.
- Zero-wait memory (`rvalid` in the same cycle as `req`): one instruction per cycle sustained; `validF` rises one cycle after accept.
- Redirect penalty with zero-wait memory:
  - redirect at cycle N → request to target at N+1, `validF` at N+2.
  - In-flight redirect adds the remaining latency of the stale request.
- Reset asserted mid-request: next cycle `imem_req=0` and all state returns to reset values. The memory must treat a dropped `req` as a cancel.

## Configuration
- `FETCH_SEQ_PERF_EN` defined:
  - Adds outputs `perf_fetched` (32; +1 per accepted, non-discarded response).
  - Adds `perf_stall` (32; +1 per cycle with `validF & stallF`).
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `fetch_pkg`:
  - state enum (IDLE/REQ/DROP).
  - `FETCH_INC = 32'd4`.
  - default `RESET_PC`.
- One sub-module, `fetch_seq_perf`: the two counters, instantiated only under `FETCH_SEQ_PERF_EN`.

## Test plan
- Reset, zero-wait memory returning `addr>>2`, no stall → `pcF` = 0,4,8,…, one per cycle; `instrF` = 0,1,2; `validF` rises on the 2nd cycle after reset release.
- `stallF=1` for 3 cycles while `instrF=0x...02` → `instrF`/`pcF=8` held; `imem_req` stays high at addr 12; no instruction lost or duplicated after release.
- 3-cycle-latency memory; redirect to 0x100 one cycle after issuing request to 0x10 → state DROP; the 0x10 response is discarded; next `imem_addr=0x100`; next valid `pcF=0x100`.
- Redirect coincident with `rvalid` and `stallF=1` → `validF=0` next cycle; response discarded; the following request targets the redirect PC.
- `faddr=0xFFFF_FFFC` accepted → next `imem_addr=0`; `pcplus4F=0`.
- With `FETCH_SEQ_PERF_EN`: 10 fetches plus 4 stall cycles → `perf_fetched=10`, `perf_stall=4`; `reset` clears both.
